// File: rtl/filter_pass_scheduler.sv
//==============================================================================
// Module      : filter_pass_scheduler
// Description : Sequences multi-pass filter runs. Launches the index generator
//               once per pass, meters issue against downstream credits, drains
//               outstanding credits, then waits for the PE array before the
//               next pass. All state updates happen on the falling clock edge.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module filter_pass_scheduler #(
    parameter int PASS_WIDTH   = 8,
    parameter int CREDIT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [PASS_WIDTH-1:0]   num_passes,
    input  logic [CREDIT_WIDTH-1:0] credit_max,
    output logic                    gen_start,
    output logic                    gen_await,
    input  logic                    gen_busy,
    input  logic                    gen_done,
    input  logic                    credit_return,
    input  logic                    pe_pass_done,
    output logic                    busy,
    output logic                    done,
    output logic [PASS_WIDTH-1:0]   pass_index,
    output logic [CREDIT_WIDTH-1:0] credits,
    output logic                    error
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_STREAM  = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_WAIT_PE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [PASS_WIDTH-1:0]   r_num_passes;
    logic [CREDIT_WIDTH-1:0] r_credit_max;
    logic                    r_pe_pending;

    logic w_start_ok;
    logic w_tracking;
    logic w_pe_window;
    logic w_pe_seen;
    logic w_last_pass;
    logic w_advance;

    // Credits are only metered while an operation is in flight, so late
    // returns after the generator finishes are still accounted for.
    assign w_start_ok  = (r_state == ST_IDLE) && start;
    assign w_tracking  = (r_state == ST_LAUNCH) || (r_state == ST_STREAM) ||
                         (r_state == ST_DRAIN)  || (r_state == ST_WAIT_PE);
    assign w_pe_window = (r_state == ST_STREAM) || (r_state == ST_DRAIN) ||
                         (r_state == ST_WAIT_PE);
    assign w_pe_seen   = pe_pass_done || r_pe_pending;
    assign w_last_pass = (pass_index == (r_num_passes - PASS_WIDTH'(1)));
    assign w_advance   = (r_state == ST_WAIT_PE) && w_pe_seen;

    // State register; reset abandons any operation without a done pulse.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        w_state_next = r_state;
        gen_start    = 1'b0;
        gen_await    = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = (num_passes == '0) ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                gen_start    = 1'b1;
                busy         = 1'b1;
                w_state_next = ST_STREAM;
            end
            ST_STREAM: begin
                busy      = 1'b1;
                gen_await = (credits == '0);
                if (gen_done) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (credits == r_credit_max) begin
                    w_state_next = ST_WAIT_PE;
                end
            end
            ST_WAIT_PE: begin
                busy = 1'b1;
                if (w_pe_seen) begin
                    w_state_next = w_last_pass ? ST_DONE : ST_LAUNCH;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Operation context, pass counter and credit accounting with sticky error.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_num_passes <= '0;
            r_credit_max <= '0;
            pass_index   <= '0;
            credits      <= '0;
            error        <= 1'b0;
        end else if (w_start_ok) begin
            r_num_passes <= num_passes;
            r_credit_max <= credit_max;
            pass_index   <= '0;
            credits      <= credit_max;
            error        <= 1'b0;
        end else begin
            if (w_tracking) begin
                if (gen_busy && !credit_return) begin
                    // Issue with no credit left is an overflow; count stays at 0.
                    if (credits == '0) begin
                        error <= 1'b1;
                    end else begin
                        credits <= credits - CREDIT_WIDTH'(1);
                    end
                end else if (credit_return && !gen_busy) begin
                    // Return with the pool already full is spurious; count stays at max.
                    if (credits == r_credit_max) begin
                        error <= 1'b1;
                    end else begin
                        credits <= credits + CREDIT_WIDTH'(1);
                    end
                end
            end
            if (w_advance && !w_last_pass) begin
                pass_index <= pass_index + PASS_WIDTH'(1);
            end
        end
    end

    // Remember an early PE completion so WAIT_PE can proceed without stalling.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_pe_pending <= 1'b0;
        end else if (w_start_ok || w_advance) begin
            r_pe_pending <= 1'b0;
        end else if (w_pe_window && pe_pass_done) begin
            r_pe_pending <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_filter_pass_scheduler.sv
//==============================================================================
// Module      : tb_filter_pass_scheduler
// Description : Self-checking bench for filter_pass_scheduler. Stimulus pushes
//               expected launch/done events into a scoreboard queue; a monitor
//               pops and compares whenever the DUT pulses gen_start or done.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_filter_pass_scheduler;

    localparam int PW = 8;
    localparam int CW = 4;

    logic          clk           = 1'b0;
    logic          reset         = 1'b1;
    logic          start         = 1'b0;
    logic [PW-1:0] num_passes    = '0;
    logic [CW-1:0] credit_max    = '0;
    logic          gen_busy      = 1'b0;
    logic          gen_done      = 1'b0;
    logic          credit_return = 1'b0;
    logic          pe_pass_done  = 1'b0;
    logic          gen_start;
    logic          gen_await;
    logic          busy;
    logic          done;
    logic [PW-1:0] pass_index;
    logic [CW-1:0] credits;
    logic          error;

    filter_pass_scheduler #(
        .PASS_WIDTH   (PW),
        .CREDIT_WIDTH (CW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .num_passes    (num_passes),
        .credit_max    (credit_max),
        .gen_start     (gen_start),
        .gen_await     (gen_await),
        .gen_busy      (gen_busy),
        .gen_done      (gen_done),
        .credit_return (credit_return),
        .pe_pass_done  (pe_pass_done),
        .busy          (busy),
        .done          (done),
        .pass_index    (pass_index),
        .credits       (credits),
        .error         (error)
    );

    // DUT acts on falling edges; the bench drives and samples on rising edges.
    always #5 clk = ~clk;

    typedef struct packed {
        logic          is_done;
        logic [PW-1:0] idx;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Scoreboard monitor: every launch or done pulse must match the queue head.
    always @(posedge clk) begin
        if (reset) begin
            if (gen_start) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gen_start", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_is_launch", 0, int'(mon_e.is_done));
                    chk("launch_pass_index", int'(pass_index), int'(mon_e.idx));
                end
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("event_is_done", 1, int'(mon_e.is_done));
                    chk("done_pass_index", int'(pass_index), int'(mon_e.idx));
                    chk("done_error", int'(error), int'(mon_e.err));
                end
            end
        end
    end

    task automatic expect_op(input int np, input logic err);
        exp_t e;
        for (int p = 0; p < np; p++) begin
            e.is_done = 1'b0; e.idx = PW'(p); e.err = 1'b0;
            sb.push_back(e);
        end
        e.is_done = 1'b1; e.idx = (np == 0) ? '0 : PW'(np - 1); e.err = err;
        sb.push_back(e);
    endtask

    task automatic tick(input logic b, input logic r, input logic gd, input logic pe);
        gen_busy = b; credit_return = r; gen_done = gd; pe_pass_done = pe;
        @(posedge clk);
        gen_busy = 1'b0; credit_return = 1'b0; gen_done = 1'b0; pe_pass_done = 1'b0;
    endtask

    task automatic do_start(input int np, input int cm);
        num_passes = PW'(np); credit_max = CW'(cm); start = 1'b1;
        @(posedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_within_budget", int'(done), 1);
        @(posedge clk);
    endtask

    // Behavioural generator: 8 indices per pass, each credit returned next cycle.
    task automatic run_auto(input int np, input int cm, input bit early_pe);
        int   remaining = 0;
        bit   active = 0, sent = 1, ret_d = 0, busy_seen = 0;
        int   pe_cnt = 0, cyc = 0, since_start = 0, pass_seen = -1;
        int   gd_cyc = -100, gs_cyc = -100, done_cyc = -1;
        logic gb, gd, pe_now;
        expect_op(np, 1'b0);
        do_start(np, cm);
        while (cyc < 400 && done_cyc < 0) begin
            if (busy) busy_seen = 1;
            if (done) done_cyc = cyc;
            if (gen_start) begin
                pass_seen++;
                remaining = 8; active = 1; sent = 0; since_start = 0;
                if (pass_seen == 1) gs_cyc = cyc;
            end
            pe_now = 1'b0;
            if (early_pe && pass_seen == 0 && since_start == 3 && active) pe_now = 1'b1;
            if (pe_cnt > 0) begin
                pe_cnt--;
                if (pe_cnt == 0) pe_now = 1'b1;
            end
            gd = active && remaining == 0 && !sent;
            if (gd) begin
                sent = 1; active = 0;
                if (pass_seen == 0) gd_cyc = cyc;
                pe_cnt = (early_pe && pass_seen == 0) ? 0 : 3;
            end
            gb = active && remaining > 0 && !gen_await;
            if (gb) remaining--;
            since_start++;
            tick(gb, ret_d, gd, pe_now);
            ret_d = gb;
            cyc++;
        end
        chk("op_completed", int'(done_cyc >= 0), 1);
        chk("launch_count", pass_seen + 1, np);
        if (np == 0) begin
            chk("zero_pass_done_latency", done_cyc, 0);
            chk("zero_pass_busy_seen", int'(busy_seen), 0);
        end
        if (early_pe) chk("early_pe_relaunch_gap", gs_cyc - gd_cyc, 3);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_gen_start"}, int'(gen_start), 0);
        chk({tag, "_gen_await"}, int'(gen_await), 1);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_pass_index"}, int'(pass_index), 0);
        chk({tag, "_credits"}, int'(credits), 0);
        chk({tag, "_error"}, int'(error), 0);
    endtask

    initial begin
        exp_t e;
        // Reset state
        #2 reset = 1'b0;
        #1 check_reset_outputs("por");
        repeat (2) @(posedge clk);
        reset = 1'b1;
        @(posedge clk);

        // Three passes, credit depth 4, immediate returns
        run_auto(3, 4, 1'b0);

        // Zero passes: done right after start, never busy, no launch
        run_auto(0, 4, 1'b0);

        // Credit exhaustion with depth 2; start/num_passes changes ignored mid-op
        expect_op(1, 1'b0);
        do_start(1, 2);
        chk("launch_credits", int'(credits), 2);
        chk("launch_await", int'(gen_await), 1);
        chk("launch_busy", int'(busy), 1);
        tick(0, 0, 0, 0);
        chk("stream_credits_2", int'(credits), 2);
        chk("stream_await_0", int'(gen_await), 0);
        start = 1'b1; num_passes = '0;
        tick(1, 0, 0, 0);
        chk("stream_credits_1", int'(credits), 1);
        chk("stream_await_1c", int'(gen_await), 0);
        tick(1, 0, 0, 0);
        chk("stream_credits_0", int'(credits), 0);
        chk("stall_await_a", int'(gen_await), 1);
        tick(0, 0, 0, 0);
        chk("stall_await_b", int'(gen_await), 1);
        tick(0, 0, 0, 0);
        chk("stall_await_c", int'(gen_await), 1);
        chk("stall_credits", int'(credits), 0);
        start = 1'b0;
        tick(0, 1, 0, 0);
        chk("return_credits_1", int'(credits), 1);
        chk("await_drops_after_return", int'(gen_await), 0);
        tick(0, 1, 0, 0);
        chk("return_credits_2", int'(credits), 2);
        tick(0, 0, 1, 0);
        chk("drain_busy", int'(busy), 1);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        wait_done(5);
        chk("idle_after_done_busy", int'(busy), 0);

        // Overflow: issue with zero credits
        expect_op(1, 1'b1);
        do_start(1, 1);
        tick(0, 0, 0, 0);
        chk("ovf_error_before", int'(error), 0);
        tick(1, 0, 0, 0);
        chk("ovf_credits_0", int'(credits), 0);
        tick(1, 0, 0, 0);
        chk("ovf_error_set", int'(error), 1);
        chk("ovf_credits_hold", int'(credits), 0);
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        chk("ovf_error_sticky", int'(error), 1);
        tick(0, 0, 0, 1);
        wait_done(5);

        // Spurious return with pool full; error cleared by the new start first
        expect_op(1, 1'b1);
        do_start(1, 1);
        chk("error_cleared_by_start", int'(error), 0);
        tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        chk("spurious_error_set", int'(error), 1);
        chk("spurious_credits_hold", int'(credits), 1);
        tick(0, 0, 1, 0);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 0);
        wait_done(5);

        // Early PE completion during pass 0 stream
        run_auto(2, 4, 1'b1);

        // Reset mid-stream of pass 1
        e.is_done = 1'b0; e.err = 1'b0;
        e.idx = PW'(0); sb.push_back(e);
        e.idx = PW'(1); sb.push_back(e);
        do_start(3, 2);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 1, 1, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("second_pass_index", int'(pass_index), 1);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("mid_stream_busy", int'(busy), 1);
        #2 reset = 1'b0;
        #1 check_reset_outputs("async_rst");
        chk("launches_consumed", sb.size(), 0);
        sb.delete();
        repeat (3) @(posedge clk);
        check_reset_outputs("held_rst");
        reset = 1'b1;
        @(posedge clk);
        run_auto(2, 3, 1'b0);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/filter_pass_scheduler.md
FILTER_PASS_SCHEDULER -- requirements
Module: filter_pass_scheduler

Interface
REQ-001 SHALL have parameters: PASS_WIDTH, default 8, width of pass count/index; CREDIT_WIDTH, default 4, width of downstream credit count.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on falling edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low (0 = reset).
REQ-004 SHALL have ports: start  in  1  begin operation; num_passes  in  PASS_WIDTH  passes to run; credit_max  in  CREDIT_WIDTH  downstream buffer depth.
REQ-005 SHALL have ports: gen_start  out  1  index-generator launch pulse; gen_await  out  1  generator stall; gen_busy  in  1  generator issued one index this cycle; gen_done  in  1  generator pass complete.
REQ-006 SHALL have ports: credit_return  in  1  downstream freed one entry; pe_pass_done  in  1  PE array finished current pass.
REQ-007 SHALL have ports: busy  out  1  operation active; done  out  1  completion pulse; pass_index  out  PASS_WIDTH  current pass; credits  out  CREDIT_WIDTH  available credits; error  out  1  sticky credit violation.

Function
REQ-008 SHALL implement states IDLE, LAUNCH, STREAM, DRAIN, WAIT_PE, DONE.
REQ-009 SHALL, in IDLE with start=1, latch num_passes and credit_max, load credits=credit_max, clear pass_index and error; go to DONE if num_passes=0, else LAUNCH.
REQ-010 SHALL ignore start in every state other than IDLE.
REQ-011 SHALL assert gen_start for exactly one cycle in LAUNCH, then go to STREAM.
REQ-012 SHALL drive gen_await=1 in all states except STREAM; in STREAM gen_await=1 iff credits=0.
REQ-013 SHALL, per cycle, decrement credits on gen_busy=1 alone, increment on credit_return=1 alone, leave unchanged on both.
REQ-014 SHALL set error (sticky until next accepted start) on gen_busy=1 with credits=0 (credits hold at 0) or credit_return=1 with credits=latched credit_max and no gen_busy (credits hold at max).
REQ-015 SHALL, in STREAM on gen_done=1, go to DRAIN.
REQ-016 SHALL, in DRAIN, go to WAIT_PE when credits equals latched credit_max.
REQ-017 SHALL capture pe_pass_done into a pending flag in STREAM, DRAIN or WAIT_PE; flag cleared when consumed.
REQ-018 SHALL, in WAIT_PE with pe_pass_done=1 or pending flag set: if pass_index=num_passes-1 go to DONE, else increment pass_index and go to LAUNCH.
REQ-019 SHALL assert done for exactly one cycle in DONE, then return to IDLE; pass_index holds final value until next start.
REQ-020 SHALL assert busy in LAUNCH, STREAM, DRAIN, WAIT_PE; deassert in IDLE and DONE.
REQ-021 SHALL ignore gen_done outside STREAM and pe_pass_done in IDLE/LAUNCH/DONE.
REQ-022 SHALL keep credit tracking active in DRAIN, WAIT_PE and LAUNCH so late returns are counted.
REQ-023 SHALL decode all unused state encodings to IDLE.

Reset
REQ-024 SHALL, while reset=0, force state IDLE, gen_start=0, gen_await=1, busy=0, done=0, pass_index=0, credits=0, error=0, pending flag=0, asynchronously.
REQ-025 SHALL abandon any operation in progress on reset assertion, with no done pulse.
REQ-026 SHALL resume normal operation on the first falling clk edge after reset deassertion.

Verification
REQ-027 SHALL cover: num_passes=3, credit_max=4, 8 indices/pass with immediate returns -> 3 gen_start pulses, pass_index 0,1,2, one done, error=0.
REQ-028 SHALL cover: credit_max=2, no credit_return for 4 cycles in STREAM -> credits 2,1,0, gen_await=1 held; one return -> gen_await drops next cycle.
REQ-029 SHALL cover: pe_pass_done pulsed during STREAM of pass 0 -> on reaching WAIT_PE immediately proceeds to LAUNCH of pass 1.
REQ-030 SHALL cover: num_passes=0, start=1 -> done one cycle after start, no gen_start, busy stays 0.
REQ-031 SHALL cover: gen_busy=1 with credits=0, and credit_return with credits=max -> error=1 sticky, cleared by next start.
REQ-032 SHALL cover: reset=0 asserted mid-STREAM of pass 1 -> all outputs at REQ-024 values immediately, no done; new start runs cleanly from pass 0.
